sort_result_reader: RTL and testbench
=====================================

Name: sort_result_reader

Overview:
Read-side counterpart of the four-entry bubble-sort datapath. The sorter is written one nibble at a time through write/writedata; this block does the reverse. On a start pulse it snapshots the four sorted register outputs (first_reg..fourth_reg). It then streams them out one element per beat over a valid/ready handshake, in ascending or descending order. It sits between the sorter's parallel outputs and any serial consumer (display driver, host bus, FIFO).

Parameters:
WIDTH, 4, bit width of each sorted element and of readdata.

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  one-cycle pulse: sorter outputs are valid, capture and begin streaming
descending  input  1  sampled with start: 0 = send first..fourth, 1 = send fourth..first
first_reg  input  WIDTH  sorted element 0 (smallest)
second_reg  input  WIDTH  sorted element 1
third_reg  input  WIDTH  sorted element 2
fourth_reg  input  WIDTH  sorted element 3 (largest)
clear  input  1  synchronous clear of sticky flags
readdata  output  WIDTH  current element being offered
valid  output  1  readdata is valid
ready  input  1  consumer accepts readdata this cycle
index  output  2  position of the current element in send order (0..3)
last  output  1  high with valid when index==3
busy  output  1  snapshot held, stream not yet finished
overrun  output  1  sticky: start arrived while busy and was dropped
order_err  output  1  sticky: captured snapshot was not nondecreasing (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; snapshot=0; index=0; dir=0; valid=0; busy=0; last=0; readdata=0; overrun=0; order_err=0.
- Reset asserted mid-stream aborts the stream immediately. No further beats are sent after release.
- States:
  - IDLE: on start, capture all four inputs and descending into internal registers on the same edge, set index=0, go to SEND.
  - SEND: valid=1, busy=1. A transfer occurs when valid&&ready. On a transfer with index<3, index increments. On a transfer with index==3, go to IDLE unless start is high in the same cycle.
- Latency: start sampled at edge N, so valid is high from cycle N+1. With ready held high, four beats are sent at edges N+1..N+4, and busy falls after edge N+4.
- readdata is a combinational select of snapshot[index] when dir=0, or snapshot[3-index] when dir=1. It is 0 when not valid.
- readdata and index stay stable while valid && !ready. Holding them stable is mandatory.
- last = valid && (index==3).
- start during SEND with no final transfer that cycle: start is ignored, the snapshot is untouched, and overrun is set.
- start during the final transfer (index==3 && ready): a new snapshot is taken, index=0, state stays SEND. Streams run back-to-back with no bubble, and overrun is not set.
- clear: synchronous, zeros overrun and order_err. If clear and a set event occur in the same cycle, the set wins.
- Inputs first_reg..fourth_reg are not required to be stable after the capture edge.

Optional Feature:
Macro SORT_READER_ORDER_CHECK_EN.
- Defined: at capture, compare adjacent inputs. If any element[k] > element[k+1], set order_err on the capture edge (visible at N+1). The flag is sticky until clear or reset.
- Not defined: order_err is tied to 0. No comparator logic is generated.
- The port exists in both builds.

Decomposition:
- Shared package sort_pkg holds:
  - constant NUM_ELEMS=4
  - constant default WIDTH=4
  - typedef enum {RD_IDLE, RD_SEND} reader_state_t
  - typedef logic [1:0] elem_idx_t
- Output selection reuses the existing multiplexer_four_input #(WIDTH) sub-module, with select = dir ? ~index : index.
- Snapshot storage is local flops. No new sub-module is needed.

Test Plan:
1. Ascending stream: inputs 1,3,7,C, descending=0, start pulse, ready=1 -> readdata 1,3,7,C on four consecutive cycles; last only with C; busy low after the 4th beat.
2. Descending plus backpressure: inputs 2,4,6,8, descending=1, ready toggled 1,0,0,1,1,0,1 -> beats 8,6,4,2 with readdata/index unchanged during every ready=0 cycle.
3. Overrun: start, then start again at beat 2 with new inputs F,F,F,F -> original four values sent; overrun=1 until clear; clear -> overrun=0.
4. Back-to-back: second start coincident with the last transfer (inputs 0,5,A,B) -> beats 0,5,A,B immediately follow with no idle cycle; overrun stays 0.
5. Async reset mid-stream: assert rst_n=0 between clock edges after beat 1 -> valid/busy drop without waiting for an edge; after release, valid stays 0 until the next start.
6. (SORT_READER_ORDER_CHECK_EN defined) capture 5,3,7,9 -> order_err=1 at N+1 and stream still sends 5,3,7,9; capture 1,2,3,4 -> no new set; build without macro -> order_err constant 0.

Source files
------------

// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_pkg                                                                   |
// | Shared constants and types for the four-entry sorter read side.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package sort_pkg;

  localparam int NUM_ELEMS     = 4;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } reader_state_t;

  typedef logic [1:0] elem_idx_t;

endpackage
`default_nettype wire

// File: rtl/multiplexer_four_input.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multiplexer_four_input                                                     |
// | Combinational 4:1 selector of WIDTH-bit words.                             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module multiplexer_four_input
  import sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  elem_idx_t        sel,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = in0;
    case (sel)
      2'd0:    data_out = in0;
      2'd1:    data_out = in1;
      2'd2:    data_out = in2;
      2'd3:    data_out = in3;
      default: data_out = in0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sort_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_result_reader                                                         |
// | Snapshots the four sorted words and streams them over valid/ready.        |
// | Optional macro: SORT_READER_ORDER_CHECK_EN (sticky order_err detection).   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             descending,
  input  logic [WIDTH-1:0] first_reg,
  input  logic [WIDTH-1:0] second_reg,
  input  logic [WIDTH-1:0] third_reg,
  input  logic [WIDTH-1:0] fourth_reg,
  input  logic             clear,
  output logic [WIDTH-1:0] readdata,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       index,
  output logic             last,
  output logic             busy,
  output logic             overrun,
  output logic             order_err
);

  reader_state_t    r_state;
  logic [WIDTH-1:0] r_snap [NUM_ELEMS];
  elem_idx_t        r_index;
  logic             r_dir;
  logic             r_valid;
  logic             r_busy;
  logic             r_overrun;

  logic             w_xfer;
  logic             w_final;
  logic             w_capture;
  elem_idx_t        w_sel;
  logic [WIDTH-1:0] w_mux_data;

  assign w_xfer    = r_valid & ready;
  assign w_final   = w_xfer & (r_index == 2'd3);
  // A start is honoured when idle or when it lands on the closing beat.
  assign w_capture = start & ((r_state == RD_IDLE) | w_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RD_IDLE;
      r_index   <= '0;
      r_dir     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NUM_ELEMS; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      if (clear) begin
        r_overrun <= 1'b0;
      end
      if (start && !w_capture) begin
        r_overrun <= 1'b1;
      end

      if (w_capture) begin
        r_snap[0] <= first_reg;
        r_snap[1] <= second_reg;
        r_snap[2] <= third_reg;
        r_snap[3] <= fourth_reg;
        r_dir     <= descending;
      end

      case (r_state)
        RD_IDLE: begin
          if (start) begin
            r_state <= RD_SEND;
            r_index <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RD_SEND: begin
          if (w_xfer) begin
            if (r_index == 2'd3) begin
              r_index <= '0;
              if (!start) begin
                r_state <= RD_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_index <= r_index + 2'd1;
            end
          end
        end
        default: begin
          r_state <= RD_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Inverting the index walks the snapshot from the top for descending order.
  assign w_sel = r_dir ? ~r_index : r_index;

  multiplexer_four_input #(
    .WIDTH (WIDTH)
  ) u_out_mux (
    .in0      (r_snap[0]),
    .in1      (r_snap[1]),
    .in2      (r_snap[2]),
    .in3      (r_snap[3]),
    .sel      (w_sel),
    .data_out (w_mux_data)
  );

  assign readdata = r_valid ? w_mux_data : '0;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign index    = r_index;
  assign last     = r_valid & (r_index == 2'd3);
  assign overrun  = r_overrun;

`ifdef SORT_READER_ORDER_CHECK_EN
  logic w_order_bad;
  logic r_order_err;

  assign w_order_bad = (first_reg > second_reg) | (second_reg > third_reg) |
                       (third_reg > fourth_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_order_err <= 1'b0;
    end else begin
      if (clear) begin
        r_order_err <= 1'b0;
      end
      if (w_capture && w_order_bad) begin
        r_order_err <= 1'b1;
      end
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sort_result_reader                                                      |
// | Directed and random stimulus against a queue-based stream model.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_sort_result_reader;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         descending;
  logic [W-1:0] first_reg, second_reg, third_reg, fourth_reg;
  logic         clear;
  logic [W-1:0] readdata;
  logic         valid;
  logic         ready;
  logic [1:0]   index;
  logic         last;
  logic         busy;
  logic         overrun;
  logic         order_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the words still owed to the consumer, in send order.
  logic [W-1:0] mq[$];
  logic         m_ovr;
  logic         m_ord;

  sort_result_reader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .descending (descending),
    .first_reg  (first_reg),
    .second_reg (second_reg),
    .third_reg  (third_reg),
    .fourth_reg (fourth_reg),
    .clear      (clear),
    .readdata   (readdata),
    .valid      (valid),
    .ready      (ready),
    .index      (index),
    .last       (last),
    .busy       (busy),
    .overrun    (overrun),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    logic [3:0][W-1:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic vld;
    vld = (mq.size() > 0);
    chk("valid", {31'd0, valid}, {31'd0, vld});
    chk("busy", {31'd0, busy}, {31'd0, vld});
    chk("last", {31'd0, last}, {31'd0, (mq.size() == 1)});
    chk("readdata", {28'd0, readdata}, vld ? {28'd0, mq[0]} : 32'd0);
    if (vld) chk("index", {30'd0, index}, 32'(4 - mq.size()));
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("order_err", {31'd0, order_err}, {31'd0, m_ord});
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_ord = 1'b0;
  endtask

  task automatic model_edge(input logic s, d, input logic [3:0][W-1:0] v, input logic r, c);
    logic xfer, fin;
    xfer = (mq.size() > 0) && r;
    fin  = xfer && (mq.size() == 1);
    if (c) begin
      m_ovr = 1'b0;
      m_ord = 1'b0;
    end
    if (s && (mq.size() > 0) && !fin) m_ovr = 1'b1;
    if (xfer) void'(mq.pop_front());
    if (s && (mq.size() == 0)) begin
      for (int k = 0; k < 4; k++) mq.push_back(d ? v[3-k] : v[k]);
`ifdef SORT_READER_ORDER_CHECK_EN
      for (int k = 0; k < 3; k++) if (v[k] > v[k+1]) m_ord = 1'b1;
`endif
    end
  endtask

  // Called at a falling edge: drive, check, advance model, wait a cycle.
  task automatic step(input logic s, d, input logic [3:0][W-1:0] v, input logic r, c);
    start      = s;
    descending = d;
    first_reg  = v[0];
    second_reg = v[1];
    third_reg  = v[2];
    fourth_reg = v[3];
    ready      = r;
    clear      = c;
    #1;
    check_outputs();
    model_edge(s, d, v, r, c);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0][W-1:0] z;
    logic [3:0][W-1:0] rv;
    logic [3:0][1:0]   rp;
    logic [6:0]        bp;
    z  = '0;
    bp = 7'b1011001;
    rst_n = 1'b0; start = 0; descending = 0; clear = 0; ready = 0;
    first_reg = 0; second_reg = 0; third_reg = 0; fourth_reg = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    chk("reset_index", {30'd0, index}, 32'd0);
    rst_n = 1'b1;

    // Ascending stream
    step(1, 0, pack4(4'h1, 4'h3, 4'h7, 4'hC), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, z, 1, 0);

    // Descending with backpressure (pattern read LSB first)
    step(1, 1, pack4(4'h2, 4'h4, 4'h6, 4'h8), 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, z, bp[i], 0);
    step(0, 0, z, 1, 0);

    // Overrun: start dropped mid-stream, then cleared
    step(1, 0, pack4(4'h1, 4'h2, 4'h3, 4'h4), 1, 0);
    step(0, 0, z, 1, 0);
    step(1, 0, pack4(4'hF, 4'hF, 4'hF, 4'hF), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, z, 1, 0);
    step(0, 0, z, 0, 1);
    step(0, 0, z, 0, 0);

    // Back-to-back: restart on the final beat
    step(1, 0, pack4(4'h9, 4'h9, 4'hA, 4'hB), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, z, 1, 0);
    step(1, 0, pack4(4'h0, 4'h5, 4'hA, 4'hB), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, z, 1, 0);

    // Asynchronous reset mid-stream
    step(1, 0, pack4(4'h3, 4'h4, 4'h5, 4'h6), 1, 0);
    step(0, 0, z, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", {31'd0, valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_readdata", {28'd0, readdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, z, 1, 0);

    // Unsorted then sorted capture
    step(1, 0, pack4(4'h5, 4'h3, 4'h7, 4'h9), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, z, 1, 0);
    step(0, 0, z, 1, 1);
    step(1, 0, pack4(4'h1, 4'h2, 4'h3, 4'h4), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, z, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rp = 8'($urandom);
        rv = pack4(4'($urandom_range(0, 3)), 4'($urandom_range(4, 7)),
                   4'($urandom_range(8, 11)), 4'($urandom_range(12, 15)));
        if (rp[0] == 2'd0) rv[1] = rv[0];
      end
      step(($urandom_range(0, 5) == 0), 1'($urandom), rv,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    #1;
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
